pmem_burst_responder: RTL and testbench

PMEM_BURST_RESPONDER -- requirements
Module: pmem_burst_responder

---
 rtl/pmem_burst_responder_if.sv | 27 ++
 rtl/pmem_burst_responder.sv | 102 ++++++++++
 tb/tb_pmem_burst_responder.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pmem_burst_responder_if.sv
// Bundles the cache-side line port and the memory-side beat port of the
// burst responder. The slave view belongs to the responder and the master
// view to whatever sits around it (the arbiter plus the memory model).
interface pmem_burst_responder_if;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic         mem_read_o;
  logic         mem_write_o;
  logic [31:0]  mem_address_o;
  logic [63:0]  mem_burst_o;
  logic [63:0]  mem_burst_i;
  logic         mem_resp_i;

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata, mem_burst_i, mem_resp_i,
    output pmem_rdata, pmem_resp, mem_read_o, mem_write_o, mem_address_o, mem_burst_o
  );

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata, mem_burst_i, mem_resp_i,
    input  pmem_rdata, pmem_resp, mem_read_o, mem_write_o, mem_address_o, mem_burst_o
  );
endinterface

// File: rtl/pmem_burst_responder.sv
// Converts one 256-bit line read/write into a 4-beat, 64-bit memory burst.
//
// state | meaning
// IDLE  | waiting for a line request; read wins over write
// READ  | mem_read_o high, collecting beats into pmem_rdata
// WRITE | mem_write_o high, presenting beats of the latched line
// DONE  | one-cycle pmem_resp pulse, then back to IDLE
//
// All outputs are registered. Beats are gated only by mem_resp_i, so the
// memory can insert any number of wait cycles between beats.
module pmem_burst_responder (
  input  logic clk,
  input  logic rst_n,
  pmem_burst_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t       state;
  logic [1:0]   beat;
  logic [1:0]   beat_nxt;
  logic [255:0] wline_q;
  logic [255:0] rdata_q;
  logic         resp_q;
  logic         rd_q;
  logic         wr_q;
  logic [31:0]  addr_q;
  logic [63:0]  wbeat_q;

  assign beat_nxt = beat + 2'd1;

  assign bus.pmem_rdata    = rdata_q;
  assign bus.pmem_resp     = resp_q;
  assign bus.mem_read_o    = rd_q;
  assign bus.mem_write_o   = wr_q;
  assign bus.mem_address_o = addr_q;
  assign bus.mem_burst_o   = wbeat_q;

  // Sequencer: state, beat counter, line buffers and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      beat    <= 2'd0;
      wline_q <= '0;
      rdata_q <= '0;
      resp_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wbeat_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          resp_q <= 1'b0;
          beat   <= 2'd0;
          if (bus.pmem_read) begin
            state  <= READ;
            rd_q   <= 1'b1;
            addr_q <= bus.pmem_address & 32'hFFFF_FFE0;
          end else if (bus.pmem_write) begin
            state   <= WRITE;
            wr_q    <= 1'b1;
            addr_q  <= bus.pmem_address & 32'hFFFF_FFE0;
            wline_q <= bus.pmem_wdata;
            wbeat_q <= bus.pmem_wdata[63:0];
          end
        end
        READ: begin
          if (bus.mem_resp_i) begin
            // Beats land straight in the output line, so the previous read
            // stays visible until the first beat of the next one.
            rdata_q[{beat, 6'b0} +: 64] <= bus.mem_burst_i;
            beat <= beat_nxt;
            if (beat == 2'd3) begin
              state  <= DONE;
              rd_q   <= 1'b0;
              resp_q <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (bus.mem_resp_i) begin
            beat <= beat_nxt;
            if (beat == 2'd3) begin
              state  <= DONE;
              wr_q   <= 1'b0;
              resp_q <= 1'b1;
            end else begin
              wbeat_q <= wline_q[{beat_nxt, 6'b0} +: 64];
            end
          end
        end
        DONE: begin
          resp_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_burst_responder.sv
// Self-checking bench for pmem_burst_responder. Completion records are
// queued when a request is issued and popped when pmem_resp appears.
// Memory acknowledge is scripted per cycle by a 16-bit pattern; bit i is
// mem_resp_i in the i-th cycle after the request is accepted.
module tb_pmem_burst_responder;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pmem_burst_responder_if bus ();

  pmem_burst_responder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic         is_read;
    logic [255:0] line;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  logic [255:0] model_rdata;
  logic [31:0]  model_addr;

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Issue one line request and run its burst against the ack pattern.
  task automatic run_txn(input string name, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [255:0] wline,
                         input logic [255:0] rline, input logic [15:0] pat);
    exp_t        e;
    int          k;
    int          ones;
    int          exp_lat;
    logic        done;
    logic [31:0] exp_addr;
    exp_addr = {addr[31:5], 5'b0};
    ones = 0;
    exp_lat = -1;
    for (int i = 0; i < 16; i++) begin
      if (pat[i]) begin
        ones++;
        if (ones == 4 && exp_lat < 0) exp_lat = i + 1;
      end
    end
    @(negedge clk);
    bus.pmem_read = rd;
    bus.pmem_write = wr;
    bus.pmem_address = addr;
    bus.pmem_wdata = wline;
    e.is_read = rd;
    e.line = rd ? rline : model_rdata;
    sb.push_back(e);
    model_addr = exp_addr;
    @(negedge clk);
    // Scramble the request inputs; the burst must not notice.
    bus.pmem_address = ~addr;
    bus.pmem_wdata = ~wline;
    k = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (bus.pmem_resp === 1'b1) begin
        checks++;
        if (cyc !== exp_lat) begin
          errors++;
          $display("FAIL %s latency: got %0d cycles, expected %0d", name, cyc, exp_lat);
        end
        e = sb.pop_front();
        checks++;
        if (bus.pmem_rdata !== e.line) begin
          errors++;
          $display("FAIL %s rdata: got %h expected %h", name, bus.pmem_rdata, e.line);
        end
        checks++;
        if (bus.mem_read_o !== 1'b0 || bus.mem_write_o !== 1'b0) begin
          errors++;
          $display("FAIL %s done_req: got rd=%b wr=%b expected 0 0", name, bus.mem_read_o, bus.mem_write_o);
        end
        if (e.is_read) model_rdata = e.line;
        bus.pmem_read = 1'b0;
        bus.pmem_write = 1'b0;
        bus.mem_resp_i = 1'b1;
        @(negedge clk);
        bus.mem_resp_i = 1'b0;
        checks++;
        if (bus.pmem_resp !== 1'b0 || bus.mem_read_o !== 1'b0 || bus.mem_write_o !== 1'b0) begin
          errors++;
          $display("FAIL %s after_done: got resp=%b rd=%b wr=%b expected 0 0 0", name,
                   bus.pmem_resp, bus.mem_read_o, bus.mem_write_o);
        end
        checks++;
        if (bus.pmem_rdata !== model_rdata) begin
          errors++;
          $display("FAIL %s rdata_hold: got %h expected %h", name, bus.pmem_rdata, model_rdata);
        end
        done = 1'b1;
      end else begin
        if (k < 4) begin
          checks++;
          if (bus.mem_read_o !== rd || bus.mem_write_o !== (wr & ~rd)) begin
            errors++;
            $display("FAIL %s req_lines: got rd=%b wr=%b expected %b %b", name,
                     bus.mem_read_o, bus.mem_write_o, rd, wr & ~rd);
          end
          checks++;
          if (bus.mem_address_o !== exp_addr) begin
            errors++;
            $display("FAIL %s address: got %h expected %h", name, bus.mem_address_o, exp_addr);
          end
          if (wr && !rd) begin
            checks++;
            if (bus.mem_burst_o !== wline[64*k +: 64]) begin
              errors++;
              $display("FAIL %s wbeat%0d: got %h expected %h", name, k, bus.mem_burst_o, wline[64*k +: 64]);
            end
          end
        end
        bus.mem_resp_i = (cyc < 16) ? pat[cyc] : 1'b0;
        bus.mem_burst_i = (rd && k < 4) ? rline[64*k +: 64] : {$urandom, $urandom};
        @(negedge clk);
        if (bus.mem_resp_i && k < 4) k++;
      end
    end
    bus.mem_resp_i = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got no pmem_resp, expected one", name);
      if (sb.size() > 0) void'(sb.pop_front());
      bus.pmem_read = 1'b0;
      bus.pmem_write = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.pmem_read = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.pmem_resp !== 1'b0 || bus.mem_read_o !== 1'b0 || bus.mem_write_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got resp=%b rd=%b wr=%b expected 0 0 0",
               bus.pmem_resp, bus.mem_read_o, bus.mem_write_o);
    end
    checks++;
    if (bus.mem_address_o !== 32'h0 || bus.mem_burst_o !== 64'h0 || bus.pmem_rdata !== 256'h0) begin
      errors++;
      $display("FAIL reset_data: got addr=%h burst=%h rdata=%h expected zeros",
               bus.mem_address_o, bus.mem_burst_o, bus.pmem_rdata);
    end
    rst_n = 1'b1;
    bus.pmem_read = 1'b0;
    model_rdata = '0;
    model_addr = '0;
    @(negedge clk);
    checks++;
    if (bus.mem_read_o !== 1'b0 || bus.pmem_resp !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got rd=%b resp=%b expected 0 0", bus.mem_read_o, bus.pmem_resp);
    end
  endtask

  task automatic test_read();
    run_txn("read_zw", 1'b1, 1'b0, 32'h0000_1234, 256'h0,
            {64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222,
             64'h1111_1111_1111_1111, 64'h0000_0000_0000_0000},
            16'h001E);
  endtask

  task automatic test_write_gaps();
    run_txn("write_gaps", 1'b0, 1'b1, 32'h8000_00FF,
            256'h01234567_89abcdef_a5a5a5a5_5a5a5a5a_deadbeef_cafef00d_76543210_89abcdef,
            256'h0, 16'h0059);
  endtask

  task automatic test_simultaneous();
    run_txn("rd_wr_both", 1'b1, 1'b1, 32'h0000_4040, rand_line(), rand_line(), 16'h001E);
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    bus.pmem_read = 1'b1;
    bus.pmem_address = 32'h0000_2000;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      bus.mem_resp_i = 1'b1;
      bus.mem_burst_i = {$urandom, $urandom};
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    model_rdata = '0;
    model_addr = '0;
    checks++;
    if (bus.pmem_resp !== 1'b0 || bus.mem_read_o !== 1'b0 || bus.mem_write_o !== 1'b0 ||
        bus.mem_address_o !== 32'h0 || bus.mem_burst_o !== 64'h0 || bus.pmem_rdata !== 256'h0) begin
      errors++;
      $display("FAIL mid_reset: got resp=%b rd=%b wr=%b addr=%h burst=%h rdata=%h expected all 0",
               bus.pmem_resp, bus.mem_read_o, bus.mem_write_o, bus.mem_address_o,
               bus.mem_burst_o, bus.pmem_rdata);
    end
    rst_n = 1'b1;
    bus.pmem_read = 1'b0;
    bus.mem_resp_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.pmem_resp !== 1'b0 || bus.mem_read_o !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_quiet: got resp=%b rd=%b expected 0 0", bus.pmem_resp, bus.mem_read_o);
      end
    end
    run_txn("read_after_reset", 1'b1, 1'b0, 32'h0000_2008, 256'h0, rand_line(), 16'h001E);
  endtask

  task automatic test_ignore_idle();
    for (int i = 0; i < 3; i++) begin
      bus.mem_resp_i = 1'b1;
      bus.pmem_address = $urandom;
      @(negedge clk);
      checks++;
      if (bus.mem_read_o !== 1'b0 || bus.mem_write_o !== 1'b0 || bus.pmem_resp !== 1'b0 ||
          bus.mem_address_o !== model_addr || bus.pmem_rdata !== model_rdata) begin
        errors++;
        $display("FAIL idle_ack: got rd=%b wr=%b resp=%b addr=%h expected 0 0 0 %h",
                 bus.mem_read_o, bus.mem_write_o, bus.pmem_resp, bus.mem_address_o, model_addr);
      end
    end
    bus.mem_resp_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    run_txn("b2b_write", 1'b0, 1'b1, 32'h0000_0100, rand_line(), 256'h0, 16'h000F);
    run_txn("b2b_read", 1'b1, 1'b0, 32'h0000_0120, 256'h0, rand_line(), 16'h000F);
  endtask

  task automatic test_random();
    logic        rd;
    logic        wr;
    logic [15:0] pat;
    for (int i = 0; i < 4; i++) begin
      rd = 1'($urandom_range(0, 1));
      wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      pat = 16'($urandom);
      pat[15:12] = 4'hF;
      run_txn("random", rd, wr, $urandom, rand_line(), rand_line(), pat);
    end
  endtask

  initial begin
    bus.pmem_read = 1'b0;
    bus.pmem_write = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_wdata = '0;
    bus.mem_burst_i = '0;
    bus.mem_resp_i = 1'b0;
    model_rdata = '0;
    model_addr = '0;
    test_reset();
    test_read();
    test_write_gaps();
    test_simultaneous();
    test_ignore_idle();
    test_reset_mid_burst();
    test_back_to_back();
    test_random();
    test_ignore_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
